// File: rtl/timer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : timer_sequencer
// Purpose  : Queues 32-bit delay requests and plays each one out on the
//            16-bit timer peripheral as a chain of <=16'hFFFF loads, pulsing
//            done once per completed request. cancel stops the timer.
// Revision : 1.0  initial release
// ============================================================================
module timer_sequencer #(
  parameter logic [15:0] LOWER_TIMER = 16'h0010,
  parameter int          DEPTH       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] delay,
  input  logic        cancel,
  input  logic        tmr_exp,
  output logic        write,
  output logic [15:0] id,
  output logic [15:0] dout,
  output logic        busy,
  output logic        full,
  output logic        done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL_CNT = CW'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   rem_q, rem_d;
  logic          write_q, write_d;
  logic [15:0]   id_q, id_d;
  logic [15:0]   dout_q, dout_d;
  logic          done_q, done_d;

  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [31:0]   head;

  // Largest chunk the 16-bit timer can count in one load.
  function automatic logic [15:0] seg(input logic [31:0] x);
    return (x > 32'h0000_FFFF) ? 16'hFFFF : x[15:0];
  endfunction

  assign fifo_empty = (count_q == '0);
  assign full       = (count_q == C_FULL_CNT);
  assign busy       = (state_q == S_WAIT) || !fifo_empty;
  assign head       = mem_q[rd_ptr_q];

  assign write = write_q;
  assign id    = id_q;
  assign dout  = dout_q;
  assign done  = done_q;

  // Next-state: cancel overrides everything, otherwise FIFO + segment sequencing.
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rem_d    = rem_q;
    write_d  = 1'b0;
    done_d   = 1'b0;
    id_d     = id_q;
    dout_d   = dout_q;
    push     = start && !full && !cancel;
    pop      = 1'b0;

    if (cancel) begin
      // Zero load stops the timer; pending work is discarded without done.
      write_d  = 1'b1;
      id_d     = LOWER_TIMER;
      dout_d   = 16'h0000;
      rem_d    = 32'd0;
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop = 1'b1;
            if (head == 32'd0) begin
              done_d = 1'b1;
            end else begin
              write_d = 1'b1;
              id_d    = LOWER_TIMER;
              dout_d  = seg(head);
              rem_d   = head - {16'h0000, seg(head)};
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (tmr_exp) begin
            if (rem_q == 32'd0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              write_d = 1'b1;
              id_d    = LOWER_TIMER;
              dout_d  = seg(rem_q);
              rem_d   = rem_q - {16'h0000, seg(rem_q)};
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (push) begin
        mem_d[wr_ptr_q] = delay;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Request storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rem_q    <= 32'd0;
      write_q  <= 1'b0;
      id_q     <= 16'h0000;
      dout_q   <= 16'h0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      write_q  <= write_d;
      id_q     <= id_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_sequencer
// Purpose  : Self-checking bench for timer_sequencer with a behavioural timer
//            peripheral and a timeline-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_timer_sequencer;

  localparam logic [15:0] C_LT    = 16'h0010;
  localparam int          C_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] delay;
  logic        cancel;
  logic        force_exp;
  logic        tmr_exp;
  logic        write;
  logic [15:0] id;
  logic [15:0] dout;
  logic        busy;
  logic        full;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Event logs: cycle index k means "high after posedge k".
  int          wr_t[$];
  logic [15:0] wr_d[$];
  logic [15:0] wr_id[$];
  int          dn_t[$];

  // Timer peripheral model.
  logic [15:0] tcnt;
  logic        tm_exp;

  timer_sequencer #(.LOWER_TIMER(C_LT), .DEPTH(C_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .delay(delay), .cancel(cancel),
    .tmr_exp(tmr_exp), .write(write), .id(id), .dout(dout), .busy(busy),
    .full(full), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Timer: a load of L raises the expiry strobe for one cycle L edges later.
  always @(posedge clk) begin
    if (reset) begin
      tcnt   <= 16'd0;
      tm_exp <= 1'b0;
    end else if (write && id == C_LT) begin
      tcnt   <= dout;
      tm_exp <= 1'b0;
    end else if (tcnt == 16'd1) begin
      tcnt   <= 16'd0;
      tm_exp <= 1'b1;
    end else begin
      tm_exp <= 1'b0;
      if (tcnt != 16'd0) tcnt <= tcnt - 16'd1;
    end
  end
  assign tmr_exp = tm_exp | force_exp;

  always @(negedge clk) begin
    if (write === 1'b1) begin
      wr_t.push_back(cyc);
      wr_d.push_back(dout);
      wr_id.push_back(id);
    end
    if (done === 1'b1) dn_t.push_back(cyc);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; delay = 32'd0; cancel = 1'b0; force_exp = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    wr_t.delete(); wr_d.delete(); wr_id.delete(); dn_t.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; delay = 32'd7; cancel = 1'b0; force_exp = 1'b0;
    step(); step();
    n_checks++;
    if ({write, done, busy, full} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got write/done/busy/full=%b want 0000", {write, done, busy, full});
    end
    n_checks++;
    if (id !== 16'h0000 || dout !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_bus: got id=%h dout=%h want 0000/0000", id, dout);
    end
    apply_reset();
  endtask

  task automatic test_single();
    int s;
    apply_reset();
    s = cyc + 1; start = 1'b1; delay = 32'd5;
    step();
    start = 1'b0;
    for (int i = 0; i < 50 && dn_t.size() == 0; i++) step();
    n_checks++;
    if (dn_t.size() != 1 || dn_t[0] != s + 8) begin
      n_fail++;
      $display("FAIL single_done: got %0d pulses first at S+%0d want 1 at S+8",
               dn_t.size(), (dn_t.size() > 0) ? dn_t[0] - s : -1);
    end
    n_checks++;
    if (wr_t.size() != 1 || wr_t[0] != s + 1 || wr_d[0] != 16'h0005 || wr_id[0] != C_LT) begin
      n_fail++;
      $display("FAIL single_write: got %0d writes want 1 at S+1 id 0010 data 0005", wr_t.size());
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_two_segment();
    int s;
    apply_reset();
    s = cyc + 1; start = 1'b1; delay = 32'h0001_0000;
    step();
    start = 1'b0;
    for (int i = 0; i < 70000 && dn_t.size() == 0; i++) step();
    n_checks++;
    if (dn_t.size() != 1 || dn_t[0] != s + 65541) begin
      n_fail++;
      $display("FAIL twoseg_done: got %0d pulses first at S+%0d want 1 at S+65541",
               dn_t.size(), (dn_t.size() > 0) ? dn_t[0] - s : -1);
    end
    n_checks++;
    if (wr_t.size() != 2) begin
      n_fail++;
      $display("FAIL twoseg_count: got %0d writes want 2", wr_t.size());
    end else begin
      n_checks++;
      if (wr_t[0] != s + 1 || wr_d[0] != 16'hFFFF || wr_t[1] != s + 65538 || wr_d[1] != 16'h0001) begin
        n_fail++;
        $display("FAIL twoseg_data: got %h@S+%0d %h@S+%0d want FFFF@S+1 0001@S+65538",
                 wr_d[0], wr_t[0] - s, wr_d[1], wr_t[1] - s);
      end
    end
  endtask

  task automatic test_zero();
    int s;
    apply_reset();
    s = cyc + 1; start = 1'b1; delay = 32'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (dn_t.size() != 1 || dn_t[0] != s + 1) begin
      n_fail++;
      $display("FAIL zero_done: got %0d pulses first at S+%0d want 1 at S+1",
               dn_t.size(), (dn_t.size() > 0) ? dn_t[0] - s : -1);
    end
    n_checks++;
    if (wr_t.size() != 0) begin
      n_fail++;
      $display("FAIL zero_write: got %0d writes want 0", wr_t.size());
    end
  endtask

  task automatic test_full();
    int s0;
    int p;
    int exp_t;
    logic [15:0] vals[5];
    apply_reset();
    vals = '{16'd200, 16'd3, 16'd4, 16'd5, 16'd6};
    s0 = cyc + 1; start = 1'b1; delay = 32'd200;
    step();
    start = 1'b0;
    step();
    for (int j = 0; j < 6; j++) begin
      start = 1'b1; delay = 32'd3 + 32'(j);
      step();
      if (j == 2) begin
        n_checks++;
        if (full !== 1'b0) begin
          n_fail++;
          $display("FAIL full_early: got full=%b want 0 after 3 queued", full);
        end
      end
      if (j == 3) begin
        n_checks++;
        if (full !== 1'b1) begin
          n_fail++;
          $display("FAIL full_set: got full=%b want 1 after 4 queued", full);
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 400 && dn_t.size() < 5; i++) step();
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (dn_t.size() != 5 || wr_t.size() != 5) begin
      n_fail++;
      $display("FAIL full_count: got %0d done %0d writes want 5/5", dn_t.size(), wr_t.size());
    end else begin
      p = s0 + 1;
      for (int k = 0; k < 5; k++) begin
        exp_t = p + int'(vals[k]) + 2;
        n_checks++;
        if (wr_d[k] != vals[k] || wr_t[k] != p || dn_t[k] != exp_t) begin
          n_fail++;
          $display("FAIL full_order%0d: got data %0d w@%0d d@%0d want %0d w@%0d d@%0d",
                   k, wr_d[k], wr_t[k] - s0, dn_t[k] - s0, vals[k], p - s0, exp_t - s0);
        end
        p = exp_t + 1;
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_busy: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_cancel();
    int s;
    apply_reset();
    s = cyc + 1; start = 1'b1; delay = 32'd100;
    step();
    delay = 32'd10;
    step();
    delay = 32'd20;
    step();
    start = 1'b0;
    step();
    cancel = 1'b1; start = 1'b1; delay = 32'd9;
    step();
    cancel = 1'b0; start = 1'b0;
    n_checks++;
    if (wr_t.size() != 2 || wr_t[1] != s + 4 || wr_d[1] != 16'h0000 || wr_id[1] != C_LT) begin
      n_fail++;
      $display("FAIL cancel_write: got %0d writes, last data %h want 2 writes, zero at S+4",
               wr_t.size(), (wr_d.size() > 0) ? wr_d[wr_d.size()-1] : 16'hxxxx);
    end
    n_checks++;
    if (busy !== 1'b0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_flush: got busy=%b full=%b want 0/0", busy, full);
    end
    for (int i = 0; i < 150; i++) begin
      force_exp = (i == 20);
      step();
    end
    force_exp = 1'b0;
    n_checks++;
    if (dn_t.size() != 0 || wr_t.size() != 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_quiet: got %0d done %0d writes busy=%b want 0/2/0",
               dn_t.size(), wr_t.size(), busy);
    end
  endtask

  task automatic test_cancel_exp();
    int s;
    apply_reset();
    s = cyc + 1; start = 1'b1; delay = 32'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if (wr_t.size() != 2 || wr_t[1] != s + 6 || wr_d[1] != 16'h0000) begin
      n_fail++;
      $display("FAIL cancelexp_write: got %0d writes want 2, zero write at S+6", wr_t.size());
    end
    n_checks++;
    if (dn_t.size() != 0) begin
      n_fail++;
      $display("FAIL cancelexp_done: got %0d done pulses want 0", dn_t.size());
    end
  endtask

  // Random traffic against a timeline model: each popped request of value v
  // issues loads at w0=pop edge, w(k+1)=wk+seg+2, and completes at the edge
  // after its last segment expires; the next pop can happen one edge later.
  task automatic test_random();
    logic [31:0] mq[$];
    logic [15:0] wmap[int];
    bit          dmap[int];
    int          e;
    int          idle_at;
    int          cur_pop;
    int          cur_done;
    int          w;
    bit          st;
    bit          cn;
    bit          acc;
    bit          ew;
    bit          ed;
    bit          eb;
    bit          ef;
    logic [31:0] dl;
    logic [31:0] v;
    logic [31:0] r;
    logic [31:0] sg;
    apply_reset();
    e = 0; idle_at = 0; cur_pop = 0; cur_done = 0;
    for (int k = 0; k < 3000; k++) begin
      st = ($urandom_range(0, 2) == 0);
      cn = ($urandom_range(0, 149) == 0);
      dl = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
      start = st; delay = dl; cancel = cn;
      @(posedge clk);
      e++;
      if (cn) begin
        mq.delete(); wmap.delete(); dmap.delete();
        wmap[e] = 16'h0000;
        idle_at = e + 1; cur_done = e;
      end else begin
        acc = st && (mq.size() < C_DEPTH);
        if (mq.size() > 0 && e >= idle_at) begin
          v = mq.pop_front();
          cur_pop = e;
          if (v == 32'd0) begin
            dmap[e] = 1'b1; idle_at = e + 1; cur_done = e;
          end else begin
            w = e; r = v;
            while (r != 32'd0) begin
              sg = (r > 32'hFFFF) ? 32'hFFFF : r;
              wmap[w] = sg[15:0];
              r = r - sg;
              w = w + int'(sg) + 2;
            end
            dmap[w] = 1'b1; cur_done = w; idle_at = w + 1;
          end
        end
        if (acc) mq.push_back(dl);
      end
      step();
      ew = wmap.exists(e);
      ed = dmap.exists(e);
      eb = (e >= cur_pop && e < cur_done) || (mq.size() > 0);
      ef = (mq.size() == C_DEPTH);
      n_checks++;
      if (write !== ew) begin
        n_fail++;
        $display("FAIL rnd_write@%0d: got %b want %b", e, write, ew);
      end
      if (ew) begin
        n_checks++;
        if (dout !== wmap[e] || id !== C_LT) begin
          n_fail++;
          $display("FAIL rnd_bus@%0d: got id=%h dout=%h want %h/%h", e, id, dout, C_LT, wmap[e]);
        end
      end
      n_checks++;
      if (done !== ed) begin
        n_fail++;
        $display("FAIL rnd_done@%0d: got %b want %b", e, done, ed);
      end
      n_checks++;
      if (busy !== eb || full !== ef) begin
        n_fail++;
        $display("FAIL rnd_flags@%0d: got busy=%b full=%b want %b/%b", e, busy, full, eb, ef);
      end
    end
    start = 1'b0; cancel = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; delay = 32'd0; cancel = 1'b0; force_exp = 1'b0;
    test_reset();
    test_single();
    test_zero();
    test_full();
    test_cancel();
    test_cancel_exp();
    test_two_segment();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_sequencer.md
# timer_sequencer

Bus initiator that drives the 16-bit timer peripheral over the shared `id`/`din`/`write` register bus. It queues 32-bit delay requests from control logic, splits each request into 16-bit timer loads, and waits for the timer's one-cycle expiry strobe after each load. It pulses `done` once per completed request. It sits between the capture/control FSMs and the timer, so no client has to manage timer registers directly.

## Interface
- `LOWER_TIMER`, 16'h0010, bus id of the timer's lower 16-bit load register (the only register written).
- `DEPTH`, 4, request FIFO depth (power of two, ≥2).
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  enqueue `delay` when high and `full` low.
- `delay`  in  32  requested delay in clk cycles (0 allowed).
- `cancel`  in  1  abort the active request and flush the queue.
- `tmr_exp`  in  1  timer expiry strobe (timer `dout`).
- `write`  out  1  bus write strobe, one cycle per load.
- `id`  out  16  bus register id.
- `dout`  out  16  bus write data (timer `din`).
- `busy`  out  1  request active or queue non-empty.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `done`  out  1  one-cycle pulse per completed request.

## Operation
- Reset values: `write`=0, `id`=16'h0000, `dout`=16'h0000, `done`=0, `busy`=0, `full`=0. FIFO is emptied, `rem`=0, state IDLE.
- FIFO: `start && !full` writes `delay`. `start` while full is dropped silently, with no other effect. Simultaneous push and pop are allowed.
- `seg(x)` = min(x, 32'h0000FFFF). `rem` is a 32-bit unsigned register; `rem - seg` never underflows.
- IDLE state, FIFO non-empty, no `cancel`: pop value `v`.
  - `v`==0: `done`<=1, stay IDLE, no bus write.
  - Otherwise: `write`<=1, `id`<=LOWER_TIMER, `dout`<=seg(v), `rem`<=v-seg(v), go to WAIT.
- WAIT state, `tmr_exp`=1, no `cancel`:
  - `rem`==0: `done`<=1, go to IDLE.
  - Otherwise: `write`<=1, `dout`<=seg(rem), `rem`<=rem-seg(rem), stay in WAIT.
- WAIT state, `tmr_exp`=0: hold; `write` returns to 0.
- `cancel` (any state): `write`<=1, `id`<=LOWER_TIMER, `dout`<=0 (stops the timer), flush FIFO, `rem`<=0, IDLE, no `done`.
  - `cancel` in IDLE with an empty FIFO still issues the zero write.
  - `cancel` beats a coincident `tmr_exp`, pop, or `start`. A `start` in the `cancel` cycle is dropped.
- A `tmr_exp` seen in IDLE is ignored.
- `write` and `done` are each high for exactly one cycle per event. `id` and `dout` hold their last values between writes.
- `busy` = (state==WAIT) | FIFO non-empty.

## Timing
- All outputs are registered except `busy` and `full`, which are combinational from registers.
- The timer asserts `tmr_exp` for one cycle, L cycles after the edge that captures a load of L.
- Single-segment request D (1..65535), `start` sampled at edge S, sequencer idle with empty FIFO:
  - pop at S+1;
  - `write` high after S+1;
  - timer loads at S+2;
  - `tmr_exp` high after S+2+D;
  - `done` high after edge S+3+D.
- Each extra segment costs seg+2 cycles. A request of n segments has `done` at S + D + 2n + 1.
- Zero delay: `done` high after S+1.
- Back-to-back requests: the next pop happens the edge after the `done` edge (IDLE sees a non-empty FIFO).

## Test plan
- Delay 5, paired with a timer model → one write (id 16'h0010, data 16'h0005) after S+1; `done` one cycle after S+8; `busy` low the following cycle.
- Delay 32'h00010000 → writes 16'hFFFF then 16'h0001; `done` at S+65536+5; exactly two `write` pulses.
- Delay 0 → no `write`; `done` after S+1.
- Six starts in consecutive cycles while the sequencer waits on a long delay with DEPTH=4:
  - `full` is high after the fourth queued start;
  - the 5th and 6th starts are dropped;
  - five `done` pulses total, in order.
- `cancel` 3 cycles into WAIT with two queued requests:
  - write of 16'h0000 next cycle;
  - FIFO empty, `busy` 0;
  - no `done`, and no later `tmr_exp` is acted on.
- `cancel` coincident with `tmr_exp` of a final segment → zero write issued, `done` stays 0.
